// File: rtl/swt16_boot_loader_pkg.sv
// Shared definitions for the swt16 boot loader: FSM state encoding and image length width.
package swt16_boot_loader_pkg;

    localparam int unsigned BOOT_LEN_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLenLo  = 3'd1,
        StLenHi  = 3'd2,
        StDataLo = 3'd3,
        StDataHi = 3'd4,
        StCheck  = 3'd5,
        StDone   = 3'd6,
        StError  = 3'd7
    } bl_state_e;

    // States in which an incoming image byte is consumed.
    function automatic logic bl_rx_state(input bl_state_e st);
        return (st == StLenLo) || (st == StLenHi) || (st == StDataLo) ||
               (st == StDataHi) || (st == StCheck);
    endfunction

endpackage

// File: rtl/swt16_boot_word_asm.sv
// Pairs LO/HI image bytes into instruction words and drives the registered PMEM write port.
module swt16_boot_word_asm
    import swt16_boot_loader_pkg::*;
#(
    parameter int unsigned PMEM_ADDR_WIDTH = 12,
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned PC_INCREMENT    = 2,
    parameter int unsigned LOAD_BASE       = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       lo_we_i,
    input  logic                       hi_we_i,
    input  logic [7:0]                 byte_i,
    output logic [PMEM_ADDR_WIDTH-1:0] pmem_addr_o,
    output logic [PMEM_WORD_WIDTH-1:0] pmem_word_o,
    output logic                       pmem_we_o,
    output logic [PMEM_ADDR_WIDTH-1:0] words_loaded_o
);

    localparam logic [PMEM_ADDR_WIDTH-1:0] BaseAddr = PMEM_ADDR_WIDTH'(LOAD_BASE);
    localparam logic [PMEM_ADDR_WIDTH-1:0] AddrStep = PMEM_ADDR_WIDTH'(PC_INCREMENT);

    logic [7:0]                 lo_q;
    logic [PMEM_WORD_WIDTH-1:0] word_q;
    logic                       we_q;
    logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PMEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Address and count advance only after the strobe has used the current address.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            addr_d = BaseAddr;
            cnt_d  = '0;
        end else if (we_q) begin
            addr_d = addr_q + AddrStep;
            cnt_d  = cnt_q + PMEM_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q   <= '0;
            word_q <= '0;
            we_q   <= 1'b0;
            addr_q <= BaseAddr;
            cnt_q  <= '0;
        end else begin
            if (lo_we_i) begin
                lo_q <= byte_i;
            end
            if (hi_we_i) begin
                word_q <= PMEM_WORD_WIDTH'({byte_i, lo_q});
            end
            we_q   <= hi_we_i;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pmem_addr_o    = addr_q;
    assign pmem_word_o    = word_q;
    assign pmem_we_o      = we_q;
    assign words_loaded_o = cnt_q;

endmodule

// File: rtl/swt16_boot_loader.sv
// swt16 program loader: byte stream -> PMEM words, holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining SWT16_BOOT_CHECKSUM_EN.
module swt16_boot_loader
    import swt16_boot_loader_pkg::*;
#(
    parameter int unsigned PMEM_ADDR_WIDTH = 12,
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned PMEM_NUM_WORDS  = 2048,
    parameter int unsigned PC_INCREMENT    = 2,
    parameter int unsigned LOAD_BASE       = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_start,
    input  logic                       in_rx_valid,
    input  logic [7:0]                 in_rx_byte,
    output logic                       out_rx_ready,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
    output logic                       out_pmem_write_en,
    output logic                       out_core_hold,
    output logic                       out_done,
    output logic                       out_error,
    output logic [PMEM_ADDR_WIDTH-1:0] out_words_loaded
);

    localparam logic [BOOT_LEN_WIDTH-1:0] MaxLen = BOOT_LEN_WIDTH'(PMEM_NUM_WORDS);
`ifdef SWT16_BOOT_CHECKSUM_EN
    localparam bl_state_e StAfterData = StCheck;
`else
    localparam bl_state_e StAfterData = StDone;
`endif

    bl_state_e                 state_q, state_d;
    logic [7:0]                len_lo_q;
    logic [BOOT_LEN_WIDTH-1:0] len_q;
    logic                      done_q, error_q, hold_q;
    logic                      accept, start_ok;
    logic [BOOT_LEN_WIDTH-1:0] len_full, next_cnt;

    assign out_rx_ready = bl_rx_state(state_q);
    assign accept       = in_rx_valid && out_rx_ready;
    assign start_ok     = in_start && (state_q inside {StIdle, StDone, StError});
    assign len_full     = {in_rx_byte, len_lo_q};
    // Words loaded once the word being accepted now has been written.
    assign next_cnt     = BOOT_LEN_WIDTH'(out_words_loaded) + BOOT_LEN_WIDTH'(1);

`ifdef SWT16_BOOT_CHECKSUM_EN
    logic [7:0] cs_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_q <= '0;
        end else if (start_ok) begin
            cs_q <= '0;
        end else if (accept && (state_q != StCheck)) begin
            cs_q <= cs_q ^ in_rx_byte;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = StLenLo;
        end else if (accept) begin
            unique case (state_q)
                StLenLo:  state_d = StLenHi;
                StLenHi: begin
                    if (len_full == '0) begin
                        state_d = StAfterData;
                    end else if (len_full > MaxLen) begin
                        state_d = StError;
                    end else begin
                        state_d = StDataLo;
                    end
                end
                StDataLo: state_d = StDataHi;
                StDataHi: state_d = (next_cnt == len_q) ? StAfterData : StDataLo;
`ifdef SWT16_BOOT_CHECKSUM_EN
                StCheck:  state_d = (in_rx_byte == cs_q) ? StDone : StError;
`endif
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            len_lo_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == StLenLo)) begin
                len_lo_q <= in_rx_byte;
            end
            if (accept && (state_q == StLenHi)) begin
                len_q <= len_full;
            end
            done_q  <= (state_d == StDone);
            error_q <= (state_d == StError);
            hold_q  <= (state_d != StDone);
        end
    end

    assign out_done      = done_q;
    assign out_error     = error_q;
    assign out_core_hold = hold_q;

    swt16_boot_word_asm #(
        .PMEM_ADDR_WIDTH (PMEM_ADDR_WIDTH),
        .PMEM_WORD_WIDTH (PMEM_WORD_WIDTH),
        .PC_INCREMENT    (PC_INCREMENT),
        .LOAD_BASE       (LOAD_BASE)
    ) u_word_asm (
        .clk_i          (clock),
        .rst_ni         (reset),
        .clear_i        (start_ok),
        .lo_we_i        (accept && (state_q == StDataLo)),
        .hi_we_i        (accept && (state_q == StDataHi)),
        .byte_i         (in_rx_byte),
        .pmem_addr_o    (out_pmem_addr),
        .pmem_word_o    (out_pmem_word),
        .pmem_we_o      (out_pmem_write_en),
        .words_loaded_o (out_words_loaded)
    );

endmodule

// File: tb/tb_swt16_boot_loader.sv
// Self-checking bench for swt16_boot_loader: table vectors, reset corners, random images.
module tb_swt16_boot_loader;

`ifdef SWT16_BOOT_CHECKSUM_EN
    localparam bit CsEn = 1'b1;
`else
    localparam bit CsEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_start = 1'b0;
    logic        in_rx_valid = 1'b0;
    logic [7:0]  in_rx_byte = 8'h00;

    logic        o0_ready, o0_we, o0_hold, o0_done, o0_err;
    logic [11:0] o0_addr, o0_words;
    logic [15:0] o0_word;
    logic        o1_ready, o1_we, o1_hold, o1_done, o1_err;
    logic [11:0] o1_addr, o1_words;
    logic [15:0] o1_word;

    always #5 clock = ~clock;

    swt16_boot_loader dut (
        .clock(clock), .reset(reset), .in_start(in_start), .in_rx_valid(in_rx_valid),
        .in_rx_byte(in_rx_byte), .out_rx_ready(o0_ready), .out_pmem_addr(o0_addr),
        .out_pmem_word(o0_word), .out_pmem_write_en(o0_we), .out_core_hold(o0_hold),
        .out_done(o0_done), .out_error(o0_err), .out_words_loaded(o0_words)
    );

    swt16_boot_loader #(.LOAD_BASE(32'hFFE)) dut_wrap (
        .clock(clock), .reset(reset), .in_start(in_start), .in_rx_valid(in_rx_valid),
        .in_rx_byte(in_rx_byte), .out_rx_ready(o1_ready), .out_pmem_addr(o1_addr),
        .out_pmem_word(o1_word), .out_pmem_write_en(o1_we), .out_core_hold(o1_hold),
        .out_done(o1_done), .out_error(o1_err), .out_words_loaded(o1_words)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [27:0] wr0_q[$];
    logic [27:0] wr1_q[$];
    logic [15:0] img_w[0:63];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (o0_we) wr0_q.push_back({o0_addr, o0_word});
        if (o1_we) wr1_q.push_back({o1_addr, o1_word});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_rx_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pulse_start, output int t_acc);
        int n;
        n = 0;
        @(negedge clock);
        in_rx_valid = 1'b1;
        in_rx_byte  = b;
        in_start    = pulse_start;
        while (!o0_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        t_acc    = cyc;
        in_start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clock);
        in_rx_valid = 1'b0;
        in_start    = 1'b1;
        @(negedge clock);
        in_start = 1'b0;
        chk("start_done", o0_done, 1'b0);
        chk("start_error", o0_err, 1'b0);
        chk("start_hold", o0_hold, 1'b1);
        chk("start_words", o0_words, 12'd0);
        chk("start_ready", o0_ready, 1'b1);
    endtask

    task automatic check_reset_values();
        chk("rst_ready", o0_ready, 1'b0);
        chk("rst_we", o0_we, 1'b0);
        chk("rst_addr", o0_addr, 12'h000);
        chk("rst_word", o0_word, 16'h0000);
        chk("rst_hold", o0_hold, 1'b1);
        chk("rst_done", o0_done, 1'b0);
        chk("rst_error", o0_err, 1'b0);
        chk("rst_words", o0_words, 12'd0);
        chk("rst_wrap_addr", o1_addr, 12'hFFE);
    endtask

    // Reference model: image bytes, outcome and PMEM writes derived from the image rules.
    task automatic run_image(input logic [15:0] len, input bit cs_force, input logic [7:0] cs_val,
                             input int max_gap, input bit mid_start,
                             output bit got_done, output int got_words, output int got_nwr,
                             output int span, output int nbytes);
        logic [7:0] bq[$];
        logic [7:0] cs;
        bit         len_bad, exp_done;
        int         exp_words, t, t_first, n;
        len_bad = (len > 16'd2048);
        bq.push_back(len[7:0]);
        bq.push_back(len[15:8]);
        if (!len_bad) begin
            for (int i = 0; i < int'(len); i++) begin
                bq.push_back(img_w[i % 64][7:0]);
                bq.push_back(img_w[i % 64][15:8]);
            end
        end
        cs = 8'h00;
        foreach (bq[i]) cs = cs ^ bq[i];
        exp_done = !len_bad;
        if (CsEn && !len_bad) begin
            bq.push_back(cs_force ? cs_val : cs);
            if (cs_force && cs_val != cs) exp_done = 1'b0;
        end
        exp_words = len_bad ? 0 : int'(len);

        do_start();
        wr0_q.delete();
        wr1_q.delete();
        t_first = 0;
        t = 0;
        foreach (bq[k]) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(bq[k], mid_start && (k == bq.size() / 2) && (k > 0), t);
            if (k == 0) t_first = t;
        end
        span   = t - t_first;
        nbytes = bq.size();
        @(negedge clock);
        in_rx_valid = 1'b0;
        n = 0;
        while (!(o0_done || o0_err) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("finish_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);

        chk("img_done", o0_done, exp_done);
        chk("img_error", o0_err, !exp_done);
        chk("img_hold", o0_hold, !exp_done);
        chk("img_words", o0_words, 12'(exp_words));
        chk("img_nwr", wr0_q.size(), exp_words);
        chk("wrap_nwr", wr1_q.size(), exp_words);
        for (int i = 0; i < exp_words && i < wr0_q.size() && i < wr1_q.size(); i++) begin
            chk("img_write", wr0_q[i], {12'(2 * i), img_w[i % 64]});
            chk("wrap_write", wr1_q[i], {12'((32'hFFE + 2 * i) % 4096), img_w[i % 64]});
        end
        got_done  = o0_done;
        got_words = int'(o0_words);
        got_nwr   = wr0_q.size();
    endtask

    typedef struct {
        logic [15:0] len;
        logic [15:0] w0, w1, w2, w3;
        bit          cs_force;
        logic [7:0]  cs_val;
        bit          exp_done;
        int          exp_words;
        int          exp_nwr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit   gd;
        int   gw, gn, span, nb, t;

        vecs[0] = '{16'h0002, 16'h1234, 16'h5678, 16'h0, 16'h0, 1'b0, 8'h00, 1'b1, 2, 2};
        vecs[1] = '{16'h0002, 16'h1234, 16'h5678, 16'h0, 16'h0, 1'b1, 8'h00, !CsEn, 2, 2};
        vecs[2] = '{16'h0801, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 0, 0};
        vecs[3] = '{16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b1, 0, 0};
        vecs[4] = '{16'h0001, 16'hABCD, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00, 1'b1, 1, 1};
        vecs[5] = '{16'h0004, 16'h0001, 16'h0203, 16'hFFFF, 16'h8000, 1'b0, 8'h00, 1'b1, 4, 4};

        repeat (2) @(negedge clock);
        check_reset_values();
        reset = 1'b1;
        @(negedge clock);
        check_reset_values();

        foreach (vecs[v]) begin
            img_w[0] = vecs[v].w0;
            img_w[1] = vecs[v].w1;
            img_w[2] = vecs[v].w2;
            img_w[3] = vecs[v].w3;
            run_image(vecs[v].len, vecs[v].cs_force, vecs[v].cs_val, 1, 1'b0, gd, gw, gn, span, nb);
            chk("vec_done", gd, vecs[v].exp_done);
            chk("vec_words", gw, vecs[v].exp_words);
            chk("vec_nwr", gn, vecs[v].exp_nwr);
        end

        // Full-rate stream: one byte per cycle with valid held high.
        for (int i = 0; i < 8; i++) img_w[i] = 16'(32'h1111 * (i + 1));
        run_image(16'd8, 1'b0, 8'h00, 0, 1'b0, gd, gw, gn, span, nb);
        chk("b2b_span", span, nb - 1);

        // Reset after three data bytes, then reload from address 0.
        img_w[0] = 16'h1234;
        img_w[1] = 16'h5678;
        do_start();
        send_byte(8'h02, 1'b0, t);
        send_byte(8'h00, 1'b0, t);
        send_byte(8'h34, 1'b0, t);
        send_byte(8'h12, 1'b0, t);
        send_byte(8'h78, 1'b0, t);
        reset = 1'b0;
        in_rx_valid = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;
        run_image(16'd2, 1'b0, 8'h00, 1, 1'b0, gd, gw, gn, span, nb);

        // Reset in the strobe cycle drops the pending write.
        do_start();
        send_byte(8'h01, 1'b0, t);
        send_byte(8'h00, 1'b0, t);
        wr0_q.delete();
        send_byte(8'hCD, 1'b0, t);
        send_byte(8'hAB, 1'b0, t);
        reset = 1'b0;
        in_rx_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("drop_strobe", wr0_q.size(), 0);
        chk("drop_we", o0_we, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        // Random images, including over-length LEN and start pulses mid-load.
        for (int r = 0; r < 25; r++) begin
            logic [15:0] len;
            bit          force_cs;
            len = ($urandom_range(0, 9) == 0) ? 16'(2049 + $urandom_range(0, 3000))
                                               : 16'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) img_w[i] = 16'($urandom);
            force_cs = ($urandom_range(0, 4) == 0);
            run_image(len, force_cs, 8'($urandom), 2, ($urandom_range(0, 2) == 0),
                      gd, gw, gn, span, nb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
